// File: rtl/psum_drain_serializer.sv
// Snapshots the PE-array psum vector, pulses clear_psum, then streams requantised lanes over valid/ready.
// Optional feature: define PSUM_RELU_EN to clamp negative saturated results to zero.
module psum_drain_serializer #(
    parameter int unsigned DW     = 14,
    parameter int unsigned Num_PE = 16,
    parameter int unsigned OW     = 8,
    parameter int unsigned SHIFT  = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           drain_start,
    input  logic [Num_PE*DW-1:0]                           psum_in,
    output logic                                           clear_psum,
    output logic                                           busy,
    output logic [OW-1:0]                                  out_data,
    output logic [((Num_PE > 1) ? $clog2(Num_PE) : 1)-1:0] out_idx,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic                                           out_last,
    output logic                                           overrun
);

    localparam int unsigned IW = (Num_PE > 1) ? $clog2(Num_PE) : 1;
    // Wide enough to hold both the rounded value and the saturation limits with a sign bit.
    localparam int unsigned EW = (((DW + 1) > OW) ? (DW + 1) : OW) + 1;
    localparam logic [IW-1:0] LastIdx = IW'(Num_PE - 1);

    typedef enum logic [0:0] {
        StIdle,
        StStream
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] buf_q [Num_PE];
    logic [DW-1:0] buf_d [Num_PE];
    logic [IW-1:0] idx_q, idx_d;
    logic          clear_q, clear_d;
    logic          overrun_q, overrun_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        clear_d   = 1'b0;
        overrun_d = overrun_q;

        unique case (state_q)
            StIdle: begin
                if (drain_start) begin
                    for (int i = 0; i < int'(Num_PE); i++) begin
                        buf_d[i] = psum_in[i*DW +: DW];
                    end
                    idx_d   = '0;
                    clear_d = 1'b1;
                    state_d = StStream;
                end
            end
            StStream: begin
                // Starts while draining are dropped; the tile in flight is left intact.
                if (drain_start) begin
                    overrun_d = 1'b1;
                end
                if (out_ready) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            buf_q     <= '{default: '0};
            idx_q     <= '0;
            clear_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            idx_q     <= idx_d;
            clear_q   <= clear_d;
            overrun_q <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Requantisation of the selected lane
    // ------------------------------------------------------------------
    logic [DW-1:0]        lane_x;
    logic signed [DW:0]   x_ext;
    logic signed [DW:0]   y_rnd;
    logic signed [EW-1:0] y_ext;
    logic signed [EW-1:0] sat_max;
    logic signed [EW-1:0] sat_min;
    logic [OW-1:0]        y_sat;

    assign lane_x = buf_q[idx_q];
    assign x_ext  = $signed({lane_x[DW-1], lane_x});

    if (SHIFT > 0) begin : g_round
        localparam logic signed [DW:0] Half = {{DW{1'b0}}, 1'b1} << (SHIFT - 1);
        assign y_rnd = (x_ext + Half) >>> SHIFT;
    end else begin : g_pass
        assign y_rnd = x_ext;
    end

    always_comb begin
        y_ext   = $signed({{(EW - DW - 1){y_rnd[DW]}}, y_rnd});
        sat_max = $signed(({{(EW - 1){1'b0}}, 1'b1} << (OW - 1)) - {{(EW - 1){1'b0}}, 1'b1});
        sat_min = -sat_max - $signed({{(EW - 1){1'b0}}, 1'b1});
        if (y_ext > sat_max) begin
            y_sat = sat_max[OW-1:0];
        end else if (y_ext < sat_min) begin
            y_sat = sat_min[OW-1:0];
        end else begin
            y_sat = y_ext[OW-1:0];
        end
`ifdef PSUM_RELU_EN
        if (y_sat[OW-1]) begin
            y_sat = '0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy       = (state_q == StStream);
        out_valid  = busy;
        out_idx    = idx_q;
        out_last   = busy && (idx_q == LastIdx);
        out_data   = busy ? y_sat : '0;
        clear_psum = clear_q;
        overrun    = overrun_q;
    end

endmodule

// File: tb/tb_psum_drain_serializer.sv
// Randomised scoreboard bench for psum_drain_serializer; expected beats come from an arithmetic model.
module tb_psum_drain_serializer;

    localparam int DW  = 14;
    localparam int NPE = 16;
    localparam int OW  = 8;
    localparam int SH  = 2;
    localparam int IW  = 4;
`ifdef PSUM_RELU_EN
    localparam bit Relu = 1'b1;
`else
    localparam bit Relu = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              drain_start;
    logic [NPE*DW-1:0] psum_in;
    logic              clear_psum, busy, out_valid, out_ready, out_last, overrun;
    logic [OW-1:0]     out_data;
    logic [IW-1:0]     out_idx;

    // Second instance: SHIFT=0, OW=DW pass-through.
    logic              d6_start, d6_clear, d6_busy, d6_valid, d6_ready, d6_last, d6_overrun;
    logic [NPE*DW-1:0] d6_psum;
    logic [DW-1:0]     d6_data;
    logic [IW-1:0]     d6_idx;

    always #5 clk = ~clk;

    psum_drain_serializer #(.DW(DW), .Num_PE(NPE), .OW(OW), .SHIFT(SH)) u_dut (
        .clk(clk), .rst(rst), .drain_start(drain_start), .psum_in(psum_in),
        .clear_psum(clear_psum), .busy(busy), .out_data(out_data), .out_idx(out_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .overrun(overrun)
    );

    psum_drain_serializer #(.DW(DW), .Num_PE(NPE), .OW(DW), .SHIFT(0)) u_dut6 (
        .clk(clk), .rst(rst), .drain_start(d6_start), .psum_in(d6_psum),
        .clear_psum(d6_clear), .busy(d6_busy), .out_data(d6_data), .out_idx(d6_idx),
        .out_valid(d6_valid), .out_ready(d6_ready), .out_last(d6_last), .overrun(d6_overrun)
    );

    typedef struct {
        int data;
        int idx;
        int last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   hs_count = 0;
    int   clr_count = 0;
    int   ready_pct = 100;
    int   lane_v[NPE];
    logic          held = 1'b0;
    logic [OW-1:0] held_data;
    logic [IW-1:0] held_idx;

    function automatic int quant(int x, int sh, int ow, bit relu);
        int y, hi, lo;
        y  = (sh > 0) ? ((x + (1 << (sh - 1))) >>> sh) : x;
        hi = (1 << (ow - 1)) - 1;
        lo = -(1 << (ow - 1));
        if (y > hi) y = hi;
        if (y < lo) y = lo;
        if (relu && y < 0) y = 0;
        return y;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake, checks hold-stability under backpressure.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (clear_psum) clr_count++;
            check("busy_eq_valid", int'(busy), int'(out_valid));
            if (!out_valid) begin
                check("idle_data_zero", int'(out_data), 0);
                check("idle_last_zero", int'(out_last), 0);
            end
            if (held) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'(out_data), int'(held_data));
                check("hold_idx", int'(out_idx), int'(held_idx));
            end
            if (out_valid && out_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat_idx", int'(out_idx), -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("beat_data", int'($signed(out_data)), e.data);
                    check("beat_idx", int'(out_idx), e.idx);
                    check("beat_last", int'(out_last), e.last);
                end
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            held_idx  = out_idx;
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic rand_lanes();
        for (int i = 0; i < NPE; i++) lane_v[i] = int'($urandom_range(0, 16383)) - 8192;
    endtask

    task automatic scramble_psum();
        for (int i = 0; i < NPE; i++) psum_in[i*DW +: DW] = DW'($urandom);
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 of the first beat cycle.
    task automatic do_start();
        for (int i = 0; i < NPE; i++) begin
            logic [31:0] v;
            exp_t e;
            v = lane_v[i];
            psum_in[i*DW +: DW] = v[DW-1:0];
            e.data = quant(lane_v[i], SH, OW, Relu);
            e.idx  = i;
            e.last = (i == NPE - 1) ? 1 : 0;
            exp_q.push_back(e);
        end
        drain_start = 1'b1;
        @(posedge clk);
        #1;
        drain_start = 1'b0;
        scramble_psum();
        check("start_clear_pulse", int'(clear_psum), 1);
        check("start_first_valid", int'(out_valid), 1);
        check("start_first_idx", int'(out_idx), 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_done_in_budget", int'(n < 2000), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_tile(input int pct, input bit ramp);
        int hs0, clr0;
        ready_pct = pct;
        if (ramp) begin
            for (int i = 0; i < NPE; i++) lane_v[i] = 4 * i;
        end
        hs0  = hs_count;
        clr0 = clr_count;
        do_start();
        wait_idle();
        check("tile_handshakes", hs_count - hs0, NPE);
        check("tile_clear_pulses", clr_count - clr0, 1);
    endtask

    initial begin
        int clr0;
        rst = 1'b1;
        drain_start = 1'b0;
        psum_in = '0;
        d6_start = 1'b0;
        d6_psum = '0;
        d6_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_clear", int'(clear_psum), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_idx", int'(out_idx), 0);
        @(posedge clk);
        #1;

        // Basic ramp, always ready.
        run_tile(100, 1'b1);

        // Rounding and saturation corners.
        rand_lanes();
        lane_v[0] = 100; lane_v[1] = -100; lane_v[2] = 8191; lane_v[3] = -8192; lane_v[4] = 6;
        lane_v[5] = -6;  lane_v[6] = 2;    lane_v[7] = -2;   lane_v[8] = 511;  lane_v[9] = -514;
        run_tile(100, 1'b0);

        // Backpressure with the ramp, then random tiles.
        run_tile(30, 1'b1);
        for (int k = 0; k < 4; k++) begin
            rand_lanes();
            run_tile(int'($urandom_range(20, 90)), 1'b0);
        end

        // Overrun: start at beat 5 and on the final handshake cycle.
        ready_pct = 100;
        @(posedge clk);
        #1;
        rand_lanes();
        clr0 = clr_count;
        do_start();
        repeat (5) @(posedge clk);
        #1;
        check("ovr_at_beat5_idx", int'(out_idx), 5);
        drain_start = 1'b1;
        @(posedge clk);
        #1;
        drain_start = 1'b0;
        check("ovr_sticky_set", int'(overrun), 1);
        repeat (9) @(posedge clk);
        #1;
        check("ovr_final_last", int'(out_last), 1);
        drain_start = 1'b1;
        @(posedge clk);
        #1;
        drain_start = 1'b0;
        check("ovr_bubble_idle", int'(busy), 0);
        check("ovr_bubble_clear", int'(clear_psum), 0);
        rand_lanes();
        do_start();
        wait_idle();
        check("ovr_clear_count", clr_count - clr0, 2);
        check("ovr_still_set", int'(overrun), 1);

        // Reset mid-stream at beat 7.
        @(posedge clk);
        #1;
        rand_lanes();
        do_start();
        repeat (7) @(posedge clk);
        #1;
        check("mid_idx_before_rst", int'(out_idx), 7);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        check("mid_rst_data", int'(out_data), 0);
        check("mid_rst_idx", int'(out_idx), 0);
        check("mid_rst_last", int'(out_last), 0);
        rand_lanes();
        run_tile(60, 1'b0);

        // Pass-through instance: SHIFT=0, OW=14.
        rand_lanes();
        lane_v[0] = -8192;
        lane_v[1] = 8191;
        for (int i = 0; i < NPE; i++) begin
            logic [31:0] v;
            v = lane_v[i];
            d6_psum[i*DW +: DW] = v[DW-1:0];
        end
        d6_start = 1'b1;
        @(posedge clk);
        #1;
        d6_start = 1'b0;
        d6_psum = '0;
        for (int i = 0; i < NPE; i++) begin
            @(negedge clk);
            check("pt_valid", int'(d6_valid), 1);
            check("pt_idx", int'(d6_idx), i);
            check("pt_data", int'($signed(d6_data)), quant(lane_v[i], 0, DW, Relu));
            @(posedge clk);
            #1;
        end
        check("pt_done", int'(d6_busy), 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
